// File: rtl/spi_cfg_slave_pkg.sv
// ============================================================================
// Module  : spi_cfg_pkg
// Brief   : Frame geometry, counter constants and FSM state encoding for the
//           SPI configuration responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_cfg_pkg;

  localparam int FRAME_LEN = 24;
  localparam int HDR_LEN   = 16;

  // Bit positions inside the 24-bit frame (MSB first on the wire)
  localparam int RW_BIT  = 23;
  localparam int W_HI    = 22;
  localparam int W_LO    = 21;
  localparam int ADDR_HI = 20;
  localparam int ADDR_LO = 8;

  // The header arrives first, so at the 16th edge it sits this far below its frame position
  localparam int HDR_SHIFT = FRAME_LEN - HDR_LEN;

  localparam int                CNT_W        = 5;
  localparam logic [CNT_W-1:0]  CNT_MAX      = 5'd31;
  localparam logic [CNT_W-1:0]  CNT_FRAME    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]  CNT_HDR_LAST = CNT_W'(HDR_LEN - 1);

  typedef enum logic [2:0] {
    ST_ABORT = 3'd0,
    ST_IDLE  = 3'd1,
    ST_HDR   = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_cfg_slave_if.sv
// ============================================================================
// Module  : spi_cfg_slave_if
// Brief   : SPI pins plus register-side strobes of the configuration responder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_cfg_slave_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);

  logic              SPI_clk;
  logic              CS;
  logic              MOSI;
  logic              MISO;
  logic              MISO_oe;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  SPI_clk, CS, MOSI, rd_data,
    output MISO, MISO_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );

  modport master (
    output SPI_clk, CS, MOSI, rd_data,
    input  MISO, MISO_oe, wr_valid, wr_addr, wr_data, rd_req, rd_addr, frame_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/spi_cfg_slave_sync.sv
// ============================================================================
// Module  : spi_pin_sync
// Brief   : Synchronizes SPI_clk/CS/MOSI into clk and derives edge pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  input  logic cs,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic cs_s,
  output logic mosi_s
);

  // Each stage holds {mosi, cs, sck}; prev holds {cs, sck} one cycle older
  logic [SYNC_STAGES-1:0][2:0] sync_d, sync_q;
  logic [1:0]                  prev_d, prev_q;
  logic                        sck_s;

  if (SYNC_STAGES == 1) begin : g_one_stage
    assign sync_d[0] = {mosi, cs, spi_clk};
  end else begin : g_multi_stage
    assign sync_d = {sync_q[SYNC_STAGES-2:0], {mosi, cs, spi_clk}};
  end

  always_comb begin
    prev_d = sync_q[SYNC_STAGES-1][1:0];
  end

  // CS resets to its asserted level so a frame in flight at reset release is never picked up half-way
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sck_s    = sync_q[SYNC_STAGES-1][0];
  assign cs_s     = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][2];
  assign sck_rise =  sck_s & ~prev_q[0];
  assign sck_fall = ~sck_s &  prev_q[0];
  assign cs_rise  =  cs_s  & ~prev_q[1];
  assign cs_fall  = ~cs_s  &  prev_q[1];

endmodule

`default_nettype wire

// File: rtl/spi_cfg_slave.sv
// ============================================================================
// Module  : spi_cfg_slave
// Brief   : Oversampling SPI responder: decodes 24-bit write frames into a
//           register strobe and serves read frames on MISO.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_cfg_slave
  import spi_cfg_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  spi_cfg_slave_if.slave  bus
);

  logic sck_rise, sck_fall, cs_rise, cs_fall, cs_s, mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .spi_clk  (bus.SPI_clk),
    .cs       (bus.CS),
    .mosi     (bus.MOSI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .cs_s     (cs_s),
    .mosi_s   (mosi_s)
  );

  state_e               state_d, state_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [FRAME_LEN-1:0] rx_d, rx_q, w_rx_next;
  logic [DATA_W-1:0]    tx_d, tx_q;
  logic                 rd_cap_d, rd_cap_q;
  logic                 miso_d, miso_q, miso_oe_d, miso_oe_q;
  logic                 wr_valid_d, wr_valid_q, rd_req_d, rd_req_q;
  logic                 frame_err_d, frame_err_q, busy_d, busy_q;
  logic [ADDR_W-1:0]    wr_addr_d, wr_addr_q, rd_addr_d, rd_addr_q;
  logic [DATA_W-1:0]    wr_data_d, wr_data_q;

  assign w_rx_next = {rx_q[FRAME_LEN-2:0], mosi_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rd_cap_d    = rd_req_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    frame_err_d = 1'b0;
    busy_d      = busy_q;

    if (rd_cap_q) begin
      tx_d = bus.rd_data;
    end

    case (state_q)
      ST_ABORT: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_HDR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        // CS rise closes the frame and masks any SPI_clk edge seen in the same cycle
        if (cs_rise) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (cnt_q != '0) begin
            if (cnt_q == CNT_FRAME && rx_q[W_HI:W_LO] == 2'b00) begin
              if (!rx_q[RW_BIT]) begin
                wr_valid_d = 1'b1;
                wr_addr_d  = rx_q[ADDR_LO +: ADDR_W];
                wr_data_d  = rx_q[DATA_W-1:0];
              end
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else begin
          if (sck_rise) begin
            rx_d = w_rx_next;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (state_q == ST_HDR && cnt_q == CNT_HDR_LAST) begin
              if (w_rx_next[RW_BIT-HDR_SHIFT]) begin
                state_d   = ST_RDATA;
                rd_req_d  = 1'b1;
                rd_addr_d = w_rx_next[ADDR_LO-HDR_SHIFT +: ADDR_W];
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
          if (sck_fall && state_q == ST_RDATA) begin
            miso_d    = tx_q[DATA_W-1];
            tx_d      = tx_q << 1;
            miso_oe_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_ABORT;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_cap_q    <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_cap_q    <= rd_cap_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.MISO      = miso_q;
  assign bus.MISO_oe   = miso_oe_q;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_cfg_slave.sv
// ============================================================================
// Module  : tb_spi_cfg_slave
// Brief   : Scoreboard bench driving mode-0 SPI frames into spi_cfg_slave.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_cfg_slave;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 5;
  localparam int MIN_GAP     = 4;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_WR   = 2'd1;
  localparam logic [1:0] EV_RD   = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } evt_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  int   evt_cyc = 0;
  int   cs_rise_cyc = 0;
  int   n_evt   = 0;
  evt_t sb[$];

  spi_cfg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_cfg_slave #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic push(input logic [1:0] kind, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
    evt_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctrl"}, 32'({bus.MISO, bus.MISO_oe, bus.wr_valid, bus.rd_req,
                              bus.frame_err, bus.busy}), 32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
  endtask

  // Shifts nbits of 'bits' MSB-first; rst_at >= 0 pulses sys_rst for 2 cycles before that bit
  task automatic send_frame(input logic [31:0] bits, input int nbits, input int rst_at,
                            input bit is_rd, input logic [7:0] miso_exp, input int gap);
    logic [31:0] sh;
    sh = bits;
    bus.CS = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk_reset_outs("rst_mid");
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("busy_after_rst", 32'(bus.busy), 32'd0);
        wait_cyc(1);
      end
      bus.MOSI = sh[31];
      sh = sh << 1;
      wait_cyc(HALF);
      if (is_rd) begin
        chk($sformatf("oe_rise%0d", i + 1), 32'(bus.MISO_oe), 32'(i >= 16));
        if (i >= 16) chk($sformatf("miso_rise%0d", i + 1), 32'(bus.MISO), 32'(miso_exp[23 - i]));
      end
      bus.SPI_clk = 1'b1;
      if (i == 12 && rst_at < 0) chk("busy_mid", 32'(bus.busy), 32'd1);
      wait_cyc(HALF);
      bus.SPI_clk = 1'b0;
    end
    wait_cyc(HALF);
    bus.CS = 1'b1;
    cs_rise_cyc = cyc;
    wait_cyc(gap);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst && (bus.wr_valid || bus.rd_req || bus.frame_err)) begin
      evt_t got;
      evt_t exp;
      got.kind = bus.wr_valid ? EV_WR : (bus.rd_req ? EV_RD : EV_ERR);
      got.addr = bus.wr_valid ? bus.wr_addr : (bus.rd_req ? bus.rd_addr : '0);
      got.data = bus.wr_valid ? bus.wr_data : '0;
      evt_cyc = cyc;
      n_evt++;
      chk("one_pulse", 32'(int'(bus.wr_valid) + int'(bus.rd_req) + int'(bus.frame_err)), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_evt", 32'(got.kind), 32'(EV_NONE));
      end else begin
        exp = sb.pop_front();
        chk("evt_kind", 32'(got.kind), 32'(exp.kind));
        chk("evt_addr", 32'(got.addr), 32'(exp.addr));
        chk("evt_data", 32'(got.data), 32'(exp.data));
      end
    end
  end

  initial begin
    bus.SPI_clk = 1'b0;
    bus.CS      = 1'b1;
    bus.MOSI    = 1'b0;
    bus.rd_data = 8'hA5;
    sys_rst     = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_reset_outs("rst_init");
    @(posedge sys_clk);
    #2;
    sys_rst = 1'b0;
    wait_cyc(8);

    // Plain write, also used to measure CS-rise to strobe latency
    push(EV_WR, 13'h0001, 8'h55);
    send_frame(32'h0001_5500, 24, -1, 1'b0, 8'h00, 10);
    chk("wr_latency", 32'(evt_cyc - cs_rise_cyc), 32'(SYNC_STAGES + 1));

    // Read: header 0x8003, responder data 0xA5
    push(EV_RD, 13'h0003, 8'h00);
    send_frame(32'h8003_0000, 24, -1, 1'b1, 8'hA5, 10);
    chk("oe_after_cs", 32'(bus.MISO_oe), 32'd0);
    chk("miso_after_cs", 32'(bus.MISO), 32'd0);

    // Length errors
    push(EV_ERR, '0, '0);
    send_frame(32'h0001_5500, 20, -1, 1'b0, 8'h00, 10);
    chk("err_latency", 32'(evt_cyc - cs_rise_cyc), 32'(SYNC_STAGES + 1));
    push(EV_ERR, '0, '0);
    send_frame(32'h0001_5550, 28, -1, 1'b0, 8'h00, 10);

    // Unsupported W field
    push(EV_ERR, '0, '0);
    send_frame(32'h6001_5500, 24, -1, 1'b0, 8'h00, 10);

    // CS glitch with no clocks is ignored
    bus.CS = 1'b0;
    wait_cyc(HALF);
    bus.CS = 1'b1;
    wait_cyc(10);

    // Reset at bit 10 discards the frame, then a normal write commits
    send_frame(32'h0001_3300, 24, 10, 1'b0, 8'h00, 10);
    push(EV_WR, 13'h0002, 8'hAA);
    send_frame(32'h0002_AA00, 24, -1, 1'b0, 8'h00, 10);

    // Back-to-back writes with the minimum CS gap
    push(EV_WR, 13'h0001, 8'h11);
    push(EV_WR, 13'h0002, 8'h22);
    send_frame(32'h0001_1100, 24, -1, 1'b0, 8'h00, MIN_GAP);
    send_frame(32'h0002_2200, 24, -1, 1'b0, 8'h00, 20);

    wait_cyc(20);
    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("evt_count", 32'(n_evt), 32'd8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
